// File: rtl/alarm_pkg.sv
// Shared types, limits and BCD helpers for the alarm clock controller.
// Optional snooze feature is enabled with ALARM_SNOOZE_EN.
package alarm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SET_HOUR,
    SET_MIN,
    AL_HOUR,
    AL_MIN,
    RINGING
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t hd;
    bcd_t ho;
    bcd_t md;
    bcd_t mo;
  } hhmm_t;

  localparam int unsigned MAX_HOUR_DEC      = 2;
  localparam int unsigned MAX_HOUR_ONE_AT_2 = 3;
  localparam int unsigned MAX_MIN_DEC       = 5;

  localparam logic [6:0] HOURS_PER_DAY =
    7'(MAX_HOUR_DEC * 10 + MAX_HOUR_ONE_AT_2 + 1);
  localparam logic [6:0] MINS_PER_HOUR =
    7'((MAX_MIN_DEC + 1) * 10);

  function automatic logic [6:0] bcd2bin(
    input bcd_t hi,
    input bcd_t lo
  );
    return 7'(hi) * 7'd10 + 7'(lo);
  endfunction

  function automatic logic [7:0] bin2bcd(
    input logic [6:0] v
  );
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/alarm_ctrl_bcd_time_add.sv
// Combinational hh:mm BCD adder: +N minutes and/or +1 hour, 24 h wrap.
// carry_en_i = 0 keeps minute overflow from reaching the hours.
module bcd_time_add
  import alarm_pkg::*;
(
  input  hhmm_t      t_i,
  input  logic [5:0] min_i,
  input  logic       hour_inc_i,
  input  logic       carry_en_i,
  output hhmm_t      sum_o
);

  logic [6:0] m_sum;
  logic [6:0] m_wr;
  logic [6:0] h_sum;
  logic [6:0] h_wr;
  logic       carry;
  logic [7:0] h_bcd;
  logic [7:0] m_bcd;

  always_comb begin
    m_sum = bcd2bin(t_i.md, t_i.mo) + {1'b0, min_i};
    carry = m_sum >= MINS_PER_HOUR;
    m_wr  = carry ? m_sum - MINS_PER_HOUR : m_sum;
    h_sum = bcd2bin(t_i.hd, t_i.ho)
          + {6'd0, carry & carry_en_i}
          + {6'd0, hour_inc_i};
    h_wr  = (h_sum >= HOURS_PER_DAY) ?
            h_sum - HOURS_PER_DAY : h_sum;
    h_bcd = bin2bcd(h_wr);
    m_bcd = bin2bcd(m_wr);
  end

  assign sum_o = {h_bcd, m_bcd};

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: time/alarm editing, arming and ringing FSM.
// Define ALARM_SNOOZE_EN to add snooze on btn_inc while ringing.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_ok,
  input  logic       tick_sec,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  output logic [3:0] hourdec_set,
  output logic [3:0] hourone_set,
  output logic [3:0] mindec_set,
  output logic [3:0] minone_set,
  output logic       load_time,
  output logic       alarm_armed,
  output logic       buzzer,
  output logic [1:0] edit_field,
  output logic       edit_alarm
);

  if (RING_SEC == 0 || RING_SEC > 255) begin : g_bad_ring
    $error("RING_SEC out of range");
  end
  if (SNOOZE_MIN == 0 || SNOOZE_MIN > 59) begin : g_bad_snz
    $error("SNOOZE_MIN out of range");
  end

  state_e     state_q, state_d;
  hhmm_t      edit_q, edit_d;
  hhmm_t      alarm_q, alarm_d;
  hhmm_t      set_q, set_d;
  hhmm_t      now, inc_sum;
  logic       load_q, load_d;
  logic       armed_q, armed_d;
  logic       buzz_q, buzz_d;
  logic [7:0] cnt_q, cnt_d;
  logic       match_c, match_q, match_qq;
  logic       match_rise, ring_done;
  logic       ok, mode, inc, hour_sel;
  logic       snz_go;

  assign now  = {hourdec_now, hourone_now,
                 mindec_now, minone_now};
  assign ok   = btn_ok;
  assign mode = btn_mode & ~btn_ok;
  assign inc  = btn_inc & ~btn_mode & ~btn_ok;

  assign hour_sel   = state_q inside {SET_HOUR, AL_HOUR};
  assign match_rise = match_q & ~match_qq;
  assign ring_done  = tick_sec &
                      (cnt_q == 8'(RING_SEC - 1));

  bcd_time_add u_inc (
    .t_i        (edit_q),
    .min_i      ({5'd0, ~hour_sel}),
    .hour_inc_i (hour_sel),
    .carry_en_i (1'b0),
    .sum_o      (inc_sum)
  );

`ifdef ALARM_SNOOZE_EN
  hhmm_t snz_q, snz_d, snz_sum;
  logic  snz_pend_q, snz_pend_d;

  bcd_time_add u_snz (
    .t_i        (now),
    .min_i      (6'(SNOOZE_MIN)),
    .hour_inc_i (1'b0),
    .carry_en_i (1'b1),
    .sum_o      (snz_sum)
  );

  assign snz_go  = (state_q == RINGING) & inc;
  assign match_c = armed_q &
                   ((now == alarm_q) |
                    (snz_pend_q & (now == snz_q)));

  always_comb begin
    snz_d      = snz_q;
    snz_pend_d = snz_pend_q;
    if (state_q == RINGING) begin
      if (ok || (ring_done && !snz_go)) begin
        snz_pend_d = 1'b0;
      end else if (snz_go) begin
        snz_pend_d = 1'b1;
        snz_d      = snz_sum;
      end
    end else if (ok && state_q inside {AL_HOUR, AL_MIN}) begin
      snz_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snz_q      <= '0;
      snz_pend_q <= 1'b0;
    end else begin
      snz_q      <= snz_d;
      snz_pend_q <= snz_pend_d;
    end
  end
`else
  assign snz_go  = 1'b0;
  assign match_c = armed_q & (now == alarm_q);
`endif

  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    alarm_d = alarm_q;
    set_d   = set_q;
    load_d  = 1'b0;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      // a match edge outranks buttons so the alarm is never missed
      IDLE: begin
        if (match_rise) begin
          state_d = RINGING;
          cnt_d   = '0;
        end else if (ok) begin
          armed_d = ~armed_q;
        end else if (mode) begin
          state_d = SET_HOUR;
          edit_d  = now;
        end
      end
      SET_HOUR, SET_MIN: begin
        if (ok) begin
          set_d   = edit_q;
          load_d  = 1'b1;
          state_d = IDLE;
        end else if (mode) begin
          if (state_q == SET_HOUR) begin
            state_d = SET_MIN;
          end else begin
            state_d = AL_HOUR;
            edit_d  = alarm_q;
          end
        end else if (inc) begin
          edit_d = inc_sum;
        end
      end
      AL_HOUR, AL_MIN: begin
        if (ok) begin
          alarm_d = edit_q;
          armed_d = 1'b1;
          state_d = IDLE;
        end else if (mode) begin
          state_d = (state_q == AL_HOUR) ? AL_MIN : IDLE;
        end else if (inc) begin
          edit_d = inc_sum;
        end
      end
      RINGING: begin
        if (ok || snz_go) begin
          state_d = IDLE;
        end else if (ring_done) begin
          state_d = IDLE;
        end else if (tick_sec) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    buzz_d = (state_d == RINGING);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      edit_q   <= '0;
      alarm_q  <= '0;
      set_q    <= '0;
      load_q   <= 1'b0;
      armed_q  <= 1'b0;
      buzz_q   <= 1'b0;
      cnt_q    <= '0;
      match_q  <= 1'b0;
      match_qq <= 1'b0;
    end else begin
      state_q  <= state_d;
      edit_q   <= edit_d;
      alarm_q  <= alarm_d;
      set_q    <= set_d;
      load_q   <= load_d;
      armed_q  <= armed_d;
      buzz_q   <= buzz_d;
      cnt_q    <= cnt_d;
      match_q  <= match_c;
      match_qq <= match_q;
    end
  end

  assign hourdec_set = set_q.hd;
  assign hourone_set = set_q.ho;
  assign mindec_set  = set_q.md;
  assign minone_set  = set_q.mo;
  assign load_time   = load_q;
  assign alarm_armed = armed_q;
  assign buzzer      = buzz_q;

  always_comb begin
    edit_field = 2'd0;
    edit_alarm = 1'b0;
    unique case (1'b1)
      hour_sel:                          edit_field = 2'd1;
      state_q inside {SET_MIN, AL_MIN}:  edit_field = 2'd2;
      default:                           edit_field = 2'd0;
    endcase
    edit_alarm = state_q inside {AL_HOUR, AL_MIN};
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl.
// Snooze scenario runs when ALARM_SNOOZE_EN is defined.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       btn_mode, btn_inc, btn_ok, tick_sec;
  logic [3:0] hd_now, ho_now, md_now, mo_now;
  logic [3:0] hd_set, ho_set, md_set, mo_set;
  logic       load_time, alarm_armed, buzzer;
  logic [1:0] edit_field;
  logic       edit_alarm;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alarm_ctrl #(.RING_SEC(60), .SNOOZE_MIN(5)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .btn_ok      (btn_ok),
    .tick_sec    (tick_sec),
    .hourdec_now (hd_now),
    .hourone_now (ho_now),
    .mindec_now  (md_now),
    .minone_now  (mo_now),
    .hourdec_set (hd_set),
    .hourone_set (ho_set),
    .mindec_set  (md_set),
    .minone_set  (mo_set),
    .load_time   (load_time),
    .alarm_armed (alarm_armed),
    .buzzer      (buzzer),
    .edit_field  (edit_field),
    .edit_alarm  (edit_alarm)
  );

  wire [15:0] set_t = {hd_set, ho_set, md_set, mo_set};

  task automatic set_now(input logic [15:0] t);
    {hd_now, ho_now, md_now, mo_now} = t;
  endtask

  task automatic press(input logic m, input logic i,
                       input logic o);
    btn_mode = m; btn_inc = i; btn_ok = o;
    @(negedge clk);
    btn_mode = 0; btn_inc = 0; btn_ok = 0;
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) press(0, 1, 0);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick_sec = 1;
      @(negedge clk);
      tick_sec = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ring(input string nm);
    for (int k = 0; k < 6 && buzzer !== 1'b1; k++)
      @(negedge clk);
    n_checks++;
    if (buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL %s buzzer=%b want 1", nm, buzzer);
    end
  endtask

  task automatic test_reset;
    rstn = 0;
    idle(3);
    n_checks++;
    if ({buzzer, alarm_armed, load_time, edit_alarm,
         edit_field, set_t} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset outs=%b/%b/%b/%b/%0d set=%h want 0",
               buzzer, alarm_armed, load_time, edit_alarm,
               edit_field, set_t);
    end
    rstn = 1;
    idle(2);
  endtask

  task automatic test_set_time;
    set_now(16'h1234);
    press(1, 0, 0);
    n_checks++;
    if (edit_field !== 2'd1 || edit_alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL set_hour_field f=%0d a=%b want 1/0",
               edit_field, edit_alarm);
    end
    incs(3);
    press(1, 0, 0);
    n_checks++;
    if (edit_field !== 2'd2) begin
      n_fail++;
      $display("FAIL set_min_field f=%0d want 2", edit_field);
    end
    incs(30);
    n_checks++;
    if (load_time !== 1'b0 || set_t !== 16'h0000) begin
      n_fail++;
      $display("FAIL no_early_load ld=%b set=%h want 0/0000",
               load_time, set_t);
    end
    press(0, 0, 1);
    n_checks++;
    if (load_time !== 1'b1 || set_t !== 16'h1504) begin
      n_fail++;
      $display("FAIL load_1504 ld=%b set=%h want 1/1504",
               load_time, set_t);
    end
    idle(1);
    n_checks++;
    if (load_time !== 1'b0 || set_t !== 16'h1504 ||
        edit_field !== 2'd0) begin
      n_fail++;
      $display("FAIL load_pulse ld=%b set=%h f=%0d want 0/1504/0",
               load_time, set_t, edit_field);
    end
  endtask

  task automatic test_wrap;
    set_now(16'h2359);
    press(1, 0, 0);
    incs(1);
    press(0, 0, 1);
    n_checks++;
    if (set_t !== 16'h0059) begin
      n_fail++;
      $display("FAIL hour_wrap set=%h want 0059", set_t);
    end
    press(1, 0, 0);
    press(1, 0, 0);
    incs(1);
    press(0, 0, 1);
    n_checks++;
    if (set_t !== 16'h2300) begin
      n_fail++;
      $display("FAIL min_wrap set=%h want 2300", set_t);
    end
    set_now(16'h0919);
    press(1, 0, 0);
    incs(1);
    press(1, 0, 0);
    incs(1);
    press(0, 0, 1);
    n_checks++;
    if (set_t !== 16'h1020) begin
      n_fail++;
      $display("FAIL dec_carry set=%h want 1020", set_t);
    end
  endtask

  task automatic test_alarm;
    set_now(16'h2359);
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    n_checks++;
    if (edit_alarm !== 1'b1 || edit_field !== 2'd1) begin
      n_fail++;
      $display("FAIL al_hour a=%b f=%0d want 1/1",
               edit_alarm, edit_field);
    end
    incs(7);
    press(0, 0, 1);
    n_checks++;
    if (alarm_armed !== 1'b1 || load_time !== 1'b0 ||
        set_t !== 16'h1020) begin
      n_fail++;
      $display("FAIL al_store arm=%b ld=%b set=%h want 1/0/1020",
               alarm_armed, load_time, set_t);
    end
    press(0, 0, 1);
    n_checks++;
    if (alarm_armed !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_toggle arm=%b want 0", alarm_armed);
    end
    press(0, 1, 0);
    press(0, 0, 1);
    n_checks++;
    if (alarm_armed !== 1'b1 || edit_field !== 2'd0) begin
      n_fail++;
      $display("FAIL rearm arm=%b f=%0d want 1/0",
               alarm_armed, edit_field);
    end
    set_now(16'h0659);
    idle(3);
    n_checks++;
    if (buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL early_ring buzzer=%b want 0", buzzer);
    end
    set_now(16'h0700);
    wait_ring("ring_0700");
    ticks(59);
    n_checks++;
    if (buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL ring_59 buzzer=%b want 1", buzzer);
    end
    ticks(1);
    n_checks++;
    if (buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout buzzer=%b want 0", buzzer);
    end
    idle(10);
    n_checks++;
    if (buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL retrigger buzzer=%b want 0", buzzer);
    end
    set_now(16'h0659);
    idle(3);
    set_now(16'h0700);
    wait_ring("ring_again");
    press(1, 0, 0);
`ifndef ALARM_SNOOZE_EN
    press(0, 1, 0);
`endif
    idle(1);
    n_checks++;
    if (buzzer !== 1'b1 || edit_field !== 2'd0) begin
      n_fail++;
      $display("FAIL ring_ignore buzzer=%b f=%0d want 1/0",
               buzzer, edit_field);
    end
    press(0, 0, 1);
    n_checks++;
    if (buzzer !== 1'b0 || alarm_armed !== 1'b1) begin
      n_fail++;
      $display("FAIL dismiss buzzer=%b arm=%b want 0/1",
               buzzer, alarm_armed);
    end
  endtask

  task automatic test_ok_mode_same;
    set_now(16'h1020);
    press(1, 0, 0);
    press(1, 0, 0);
    set_now(16'h1111);
    press(1, 0, 1);
    n_checks++;
    if (load_time !== 1'b1 || set_t !== 16'h1020 ||
        edit_field !== 2'd0) begin
      n_fail++;
      $display("FAIL ok_mode ld=%b set=%h f=%0d want 1/1020/0",
               load_time, set_t, edit_field);
    end
  endtask

  task automatic test_reset_mid_ring;
    set_now(16'h0659);
    idle(3);
    set_now(16'h0700);
    wait_ring("ring_pre_rst");
    rstn = 0;
    #1;
    n_checks++;
    if (buzzer !== 1'b0 || alarm_armed !== 1'b0 ||
        load_time !== 1'b0 || set_t !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_ring bz=%b arm=%b ld=%b set=%h want 0",
               buzzer, alarm_armed, load_time, set_t);
    end
    idle(2);
    rstn = 1;
    idle(3);
    n_checks++;
    if (buzzer !== 1'b0 || load_time !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst bz=%b ld=%b want 0/0",
               buzzer, load_time);
    end
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic test_snooze;
    set_now(16'h1200);
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    incs(23);
    press(1, 0, 0);
    incs(58);
    press(0, 0, 1);
    idle(3);
    set_now(16'h2358);
    wait_ring("ring_2358");
    press(0, 1, 0);
    n_checks++;
    if (buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL snooze buzzer=%b want 0", buzzer);
    end
    set_now(16'h0000);
    idle(3);
    set_now(16'h0003);
    wait_ring("ring_snooze");
    press(0, 0, 1);
    n_checks++;
    if (buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL snz_dismiss buzzer=%b want 0", buzzer);
    end
    set_now(16'h0000);
    idle(3);
    set_now(16'h0003);
    idle(6);
    n_checks++;
    if (buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL snz_cleared buzzer=%b want 0", buzzer);
    end
  endtask
`endif

  initial begin
    btn_mode = 0; btn_inc = 0; btn_ok = 0; tick_sec = 0;
    set_now(16'h0000);
    @(negedge clk);
    test_reset();
    test_set_time();
    test_wrap();
    test_alarm();
    test_ok_mode_same();
    test_reset_mid_ring();
`ifdef ALARM_SNOOZE_EN
    test_snooze();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_SEC, default 60, ring timeout in tick_sec pulses (1..255).
REQ-002 SHALL have parameter SNOOZE_MIN, default 5, snooze delay in minutes (1..59).
REQ-003 SHALL have a single clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rstn  in  1  async active-low reset.
REQ-004 SHALL have the following ports:
- btn_mode / btn_inc / btn_ok  in  1 each  debounced single-cycle button pulses.
- tick_sec  in  1  one-cycle 1 Hz pulse, same source as the watch tim_over.
- hourdec_now / hourone_now / mindec_now / minone_now  in  4 each  current BCD time from the watch.
- hourdec_set / hourone_set / mindec_set / minone_set  out  4 each  BCD time presented to the watch init inputs.
- load_time  out  1  one-cycle pulse; watch reloads from the *_set outputs.
- alarm_armed  out  1  alarm enabled.
- buzzer  out  1  high while ringing.
- edit_field  out  2  0 none, 1 hours, 2 minutes (for display blink).
- edit_alarm  out  1  editing alarm rather than time.

Function
REQ-005 SHALL implement FSM states IDLE, SET_HOUR, SET_MIN, AL_HOUR, AL_MIN, RINGING.
REQ-006 SHALL resolve simultaneous buttons as ok > mode > inc; lower-priority pulses in that cycle are ignored.
REQ-007 IDLE + btn_mode SHALL go to SET_HOUR and copy *_now into the edit registers the same cycle.
REQ-008 IDLE + btn_ok SHALL toggle alarm_armed; IDLE + btn_inc SHALL have no effect.
REQ-009 SET_HOUR + btn_inc SHALL increment the BCD hour, wrapping 09->10, 19->20, 23->00.
REQ-010 SET_MIN + btn_inc SHALL increment the BCD minute, wrapping 09->10, 59->00, with no carry into hours.
REQ-011 SET_HOUR + btn_mode SHALL go to SET_MIN; SET_MIN + btn_mode SHALL go to AL_HOUR with no load, loading alarm registers into the edit registers.
REQ-012 btn_ok in SET_HOUR/SET_MIN SHALL drive *_set from the edit registers, assert load_time for exactly 1 cycle, and go to IDLE.
REQ-013 AL_HOUR/AL_MIN SHALL use the same increment rules; AL_HOUR + mode -> AL_MIN; AL_MIN + mode -> IDLE with the alarm unchanged.
REQ-014 btn_ok in AL_HOUR/AL_MIN SHALL store the edit value as the alarm, set alarm_armed=1, clear any pending snooze, and go to IDLE.
REQ-015 match SHALL be alarm_armed && (*_now == alarm, or == snooze target while snooze pending); RINGING SHALL be entered only on a rising edge of registered match while in IDLE.
- A match edge occurring in any other state is lost.
- Still matching after dismiss SHALL NOT retrigger.
REQ-016 RINGING SHALL hold buzzer=1; btn_ok -> IDLE (dismiss, snooze cleared); RING_SEC tick_sec pulses -> IDLE (timeout, snooze cleared).
REQ-017 RINGING + btn_mode SHALL be ignored.
REQ-018 The ring counter SHALL clear on entry to RINGING; a tick_sec in the entry cycle SHALL NOT count.
REQ-019 edit_field/edit_alarm SHALL decode combinationally from state; *_set SHALL hold their value between loads.

Reset
REQ-020 On rstn low, asynchronously and regardless of state:
- state=IDLE; alarm=00:00; edit registers 00:00; *_set=0.
- load_time=0, alarm_armed=0, buzzer=0, snooze pending=0, ring counter=0.
REQ-021 Reset mid-ring or mid-edit SHALL discard all edits and SHALL NOT pulse load_time.

Configuration
REQ-022 With ALARM_SNOOZE_EN defined, RINGING + btn_inc SHALL:
- set snooze target = current time + SNOOZE_MIN, BCD with minute carry into hours and 23:59->00:xx wrap;
- set snooze pending and return to IDLE.
REQ-023 Without ALARM_SNOOZE_EN, btn_inc in RINGING SHALL be ignored, and no snooze register or adder SHALL exist.

Structure
REQ-024 Package alarm_pkg SHALL hold the state enum, a 4-bit BCD digit typedef, a hh:mm BCD struct typedef and the constants MAX_HOUR_DEC=2, MAX_HOUR_ONE_AT_2=3, MAX_MIN_DEC=5.
REQ-025 Sub-module bcd_time_add SHALL add N minutes (0..59) to a hh:mm BCD struct combinationally with full wrap; it is used for snooze and hour/minute increments.

Verification
REQ-026 Reset, now=12:34, btn_mode, inc x3, mode, inc x30, ok -> load_time single pulse, *_set=15:04.
REQ-027 Edit hour from 23, one inc -> 00; edit minute from 59, one inc -> 00 with hour unchanged.
REQ-028 Alarm set 07:00 armed, now steps 06:59->07:00 -> buzzer=1 next cycle; 60 tick_sec pulses -> buzzer=0, IDLE; now held at 07:00 -> no retrigger.
REQ-029 ALARM_SNOOZE_EN, ring at 23:58, btn_inc -> IDLE; now reaches 00:03 -> ring again; btn_ok -> buzzer=0, snooze cleared.
REQ-030 btn_ok and btn_mode in the same cycle in SET_MIN -> load_time pulse, IDLE; rstn low mid-RINGING -> buzzer=0, alarm_armed=0 immediately.
